// File: rtl/seg_scan_driver.sv
// Multiplexed multi-digit 7-segment driver: scans DIGITS nibbles onto one segment bus,
// with ghost blanking, hex glyphs, leading-zero suppression and per-frame input snapshots.
//
// state  | meaning
// BLANK  | all selects and segments off between digits (also the post-reset state)
// DRIVE  | seg_sel[idx] active, segments show the glyph of digit idx
module seg_scan_driver #(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int HEX_MODE       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bin_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     seg_sel,
    output logic [7:0]            seg_data,
    output logic                  frame_done
);

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_ONE    = DIGITS'(1);
    localparam logic [DIGITS-1:0] SEL_IDLE   = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;
    localparam logic [7:0]        SEG_IDLE   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_drive_end;
    logic                w_frame_start;

    logic [4*DIGITS-1:0] r_bin;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_en;
    logic                r_lz;

    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_en;
    logic                w_sup;
    logic                w_lead;
    logic [7:0]          w_seg;
    logic [7:0]          w_seg_act;
    logic [DIGITS-1:0]   w_sel_act;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            default: g = 7'b1110001;
        endcase
        if (HEX_MODE == 0 && nib > 4'd9) begin
            g = 7'b0000000;
        end
        return g;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_drive_end = (r_state == ST_DRIVE) && (r_cnt == DRIVE_LAST);
        case (r_state)
            ST_BLANK: begin
                if (BLANK_CYCLES == 0 || r_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (w_drive_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                    w_state_nxt = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                end
            end
        endcase
    end

    // Snapshot must land before the first glyph of digit 0 is registered;
    // without blanking that is the edge leaving the last digit of the previous frame.
    assign w_frame_start = (r_state == ST_BLANK && r_idx == '0 && r_cnt == '0) ||
                           (BLANK_CYCLES == 0 && w_drive_end && r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_dp  <= '0;
            r_en  <= '0;
            r_lz  <= 1'b0;
        end else if (w_frame_start) begin
            r_bin <= bin_data;
            r_dp  <= dp_in;
            r_en  <= en_in;
            r_lz  <= lz_en;
        end
    end

    // w_lead stays set while every nibble from the top down to i is zero
    always_comb begin
        w_nib  = '0;
        w_dp   = 1'b0;
        w_en   = 1'b0;
        w_sup  = 1'b0;
        w_lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_lead = w_lead & (r_bin[4*i +: 4] == 4'd0);
            if (r_idx == IDX_W'(i)) begin
                w_nib = r_bin[4*i +: 4];
                w_dp  = r_dp[i];
                w_en  = r_en[i];
                w_sup = r_lz && w_lead && (i != 0);
            end
        end
    end

    assign w_seg     = w_en ? {w_dp, (w_sup ? 7'd0 : f_glyph(w_nib))} : 8'd0;
    assign w_seg_act = (r_state == ST_DRIVE) ? w_seg : 8'd0;
    assign w_sel_act = (r_state == ST_DRIVE) ? (SEL_ONE << r_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sel    <= SEL_IDLE;
            seg_data   <= SEG_IDLE;
            frame_done <= 1'b0;
        end else begin
            seg_sel    <= w_sel_act ^ SEL_IDLE;
            seg_data   <= w_seg_act ^ SEG_IDLE;
            frame_done <= w_drive_end && (r_idx == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4-digit scan with hex, no-hex and
// active-high/no-blanking variants sharing one set of inputs.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] bin_data;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        lz_en;

    logic [3:0]  sel_a, sel_n, sel_h;
    logic [7:0]  data_a, data_n, data_h;
    logic        fd_a, fd_n, fd_h;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] bin;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
        logic [31:0] exp;
        logic [31:0] exp_nh;
    } vec_t;

    vec_t vecs[8];

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(2), .HEX_MODE(1),
                      .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bin_data(bin_data), .dp_in(dp_in), .en_in(en_in),
        .lz_en(lz_en), .seg_sel(sel_a), .seg_data(data_a), .frame_done(fd_a));

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(2), .HEX_MODE(0),
                      .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .bin_data(bin_data), .dp_in(dp_in), .en_in(en_in),
        .lz_en(lz_en), .seg_sel(sel_n), .seg_data(data_n), .frame_done(fd_n));

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0), .HEX_MODE(1),
                      .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .bin_data(bin_data), .dp_in(dp_in), .en_in(en_in),
        .lz_en(lz_en), .seg_sel(sel_h), .seg_data(data_h), .frame_done(fd_h));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_fd_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd_a && n < 60);
        checks++;
        if (!fd_a) begin
            errors++;
            $display("FAIL wait_fd_a: frame_done=%b after %0d cycles, expected 1", fd_a, n);
        end
    endtask

    task automatic wait_fd_h();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd_h && n < 60);
        checks++;
        if (!fd_h) begin
            errors++;
            $display("FAIL wait_fd_h: frame_done=%b after %0d cycles, expected 1", fd_h, n);
        end
    endtask

    // Called on the negedge where fd_a is seen; checks the following 24-cycle frame.
    task automatic check_frame(input string tag, input logic [31:0] exp, input logic [31:0] exp_nh,
                               input logic chg, input logic [15:0] nb);
        logic [3:0] esel;
        logic [7:0] edat, enh;
        int slot, d;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            slot = (k - 1) % 6;
            d    = (k - 1) / 6;
            if (slot >= 2) begin
                esel = ~(4'b0001 << d);
                edat = ~exp[8*d +: 8];
                enh  = ~exp_nh[8*d +: 8];
            end else begin
                esel = 4'hF;
                edat = 8'hFF;
                enh  = 8'hFF;
            end
            chk($sformatf("%s hex k=%0d", tag, k), {19'd0, sel_a, data_a, fd_a}, {19'd0, esel, edat, (k == 24)});
            chk($sformatf("%s nohex k=%0d", tag, k), {19'd0, sel_n, data_n, fd_n}, {19'd0, esel, enh, (k == 24)});
            if (chg && k == 9) bin_data = nb;
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 32'h065B4F66, 32'h065B4F66};
        vecs[1] = '{16'hABCF, 4'h0, 4'hF, 1'b0, 32'h777C3971, 32'h00000000};
        vecs[2] = '{16'h0050, 4'h8, 4'hF, 1'b1, 32'h80006D3F, 32'h80006D3F};
        vecs[3] = '{16'h0050, 4'h8, 4'hF, 1'b0, 32'hBF3F6D3F, 32'hBF3F6D3F};
        vecs[4] = '{16'h1234, 4'h0, 4'h5, 1'b0, 32'h005B0066, 32'h005B0066};
        vecs[5] = '{16'h9876, 4'h5, 4'hF, 1'b0, 32'h6FFF07FD, 32'h6FFF07FD};
        vecs[6] = '{16'h0D0E, 4'h0, 4'hF, 1'b1, 32'h005E3F79, 32'h00003F00};
        vecs[7] = '{16'h0000, 4'h0, 4'hF, 1'b1, 32'h0000003F, 32'h0000003F};

        clk      = 1'b0;
        rst_n    = 1'b0;
        bin_data = 16'h1234;
        dp_in    = 4'h0;
        en_in    = 4'hF;
        lz_en    = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset a", {19'd0, sel_a, data_a, fd_a}, {19'd0, 4'hF, 8'hFF, 1'b0});
        chk("reset h", {19'd0, sel_h, data_h, fd_h}, {19'd0, 4'h0, 8'h00, 1'b0});
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 6)
                chk($sformatf("first frame k=%0d", k), {19'd0, sel_a, data_a, fd_a}, {19'd0, 4'hE, 8'h99, 1'b0});
            else
                chk($sformatf("first frame k=%0d", k), {19'd0, sel_a, data_a, fd_a}, {19'd0, 4'hF, 8'hFF, 1'b0});
        end

        wait_fd_a();
        for (int v = 0; v < 8; v++) begin
            bin_data = vecs[v].bin;
            dp_in    = vecs[v].dp;
            en_in    = vecs[v].en;
            lz_en    = vecs[v].lz;
            check_frame($sformatf("vec%0d", v), vecs[v].exp, vecs[v].exp_nh, 1'b0, 16'h0);
        end

        // mid-frame input change must not disturb the frame in progress
        bin_data = 16'h1111;
        dp_in    = 4'h0;
        en_in    = 4'hF;
        lz_en    = 1'b0;
        check_frame("tear", 32'h06060606, 32'h06060606, 1'b1, 16'h2222);
        check_frame("after tear", 32'h5B5B5B5B, 32'h5B5B5B5B, 1'b0, 16'h0);

        // active-high, no blanking
        wait_fd_h();
        bin_data = 16'h0008;
        dp_in    = 4'b0001;
        wait_fd_h();
        for (int k = 1; k <= 16; k++) begin
            int d;
            @(negedge clk);
            d = (k - 1) / 4;
            chk($sformatf("hi k=%0d", k), {19'd0, sel_h, data_h, fd_h},
                {19'd0, 4'(4'b0001 << d), ((d == 0) ? 8'hFF : 8'h3F), (k == 16)});
        end

        // asynchronous reset in the middle of digit 1 DRIVE
        wait_fd_a();
        bin_data = 16'h1234;
        dp_in    = 4'h0;
        repeat (10) @(negedge clk);
        chk("pre-reset digit1", {19'd0, sel_a, data_a, fd_a}, {19'd0, 4'hD, 8'hB0, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("async reset a", {19'd0, sel_a, data_a, fd_a}, {19'd0, 4'hF, 8'hFF, 1'b0});
        chk("async reset n", {19'd0, sel_n, data_n, fd_n}, {19'd0, 4'hF, 8'hFF, 1'b0});
        chk("async reset h", {19'd0, sel_h, data_h, fd_h}, {19'd0, 4'h0, 8'h00, 1'b0});
        bin_data = 16'h0007;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3)
                chk("restart digit0", {19'd0, sel_a, data_a, fd_a}, {19'd0, 4'hE, 8'hF8, 1'b0});
            else
                chk($sformatf("restart blank k=%0d", k), {19'd0, sel_a, data_a, fd_a}, {19'd0, 4'hF, 8'hFF, 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
